// File: rtl/cmd_frame_tx.sv
// Key-triggered command frame transmitter: debounced keys select a command row that is streamed as one frame.
// Optional CMD_SEQNUM_EN appends an 8-bit frame sequence number to every frame.
module cmd_frame_tx #(
    parameter int NUM_CH      = 4,
    parameter int CMD_LEN     = 3,
    parameter int DEB_CYC     = 1_000_000,
    parameter int HOLDOFF_CYC = 50_000_000
) (
    input  logic                        tx_clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           key_n,
    input  logic [NUM_CH*CMD_LEN*8-1:0] cmd_table,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_data_valid,
    output logic [15:0]                 tx_data_length,
    output logic                        busy,
    output logic [2:0]                  active_ch
);

`ifdef CMD_SEQNUM_EN
    localparam int FRAME_LEN = CMD_LEN + 1;
`else
    localparam int FRAME_LEN = CMD_LEN;
`endif
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [HLD_W-1:0] HLD_LOAD = HLD_W'(HOLDOFF_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] pressed;
    logic [DEB_W-1:0]  deb_cnt [NUM_CH];

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [HLD_W-1:0]  hold_cnt, hold_nx;
    logic [2:0]        ch_nx;
    logic [2:0]        pick;
    logic              any_pressed;
    logic              cur_pressed;
    logic [31:0]       byte_sel;
    logic [7:0]        cur_byte;

`ifdef CMD_SEQNUM_EN
    localparam logic [IDX_W-1:0] SEQ_IDX = IDX_W'(CMD_LEN);
    logic [7:0] seq, seq_nx;
`endif

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    // A level flips only after DEB_CYC consecutive samples disagree with it.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            pressed <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                deb_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (raw[c] != pressed[c]) begin
                    if (deb_cnt[c] == DEB_LAST) begin
                        pressed[c] <= raw[c];
                        deb_cnt[c] <= '0;
                    end else begin
                        deb_cnt[c] <= deb_cnt[c] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[c] <= '0;
                end
            end
        end
    end

    always_comb begin
        pick = '0;
        any_pressed = |pressed;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pressed[c]) begin
                pick = 3'(c);
            end
        end
    end

    assign cur_pressed = |(pressed & (NUM_CH'(1) << active_ch));

    always_comb begin
        byte_sel = 32'(active_ch) * CMD_LEN + 32'(idx);
        cur_byte = 8'(cmd_table >> (byte_sel * 8));
`ifdef CMD_SEQNUM_EN
        if (idx == SEQ_IDX) begin
            cur_byte = seq;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        hold_nx  = hold_cnt;
        ch_nx    = active_ch;
`ifdef CMD_SEQNUM_EN
        seq_nx   = seq;
`endif
        unique case (state)
            IDLE: begin
                if (any_pressed) begin
                    ch_nx    = pick;
                    idx_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        hold_nx  = HLD_LOAD;
                        state_nx = HOLD;
`ifdef CMD_SEQNUM_EN
                        seq_nx   = seq + 8'd1;
`endif
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    idx_nx   = '0;
                    state_nx = cur_pressed ? SEND : IDLE;
                end else begin
                    hold_nx = hold_cnt - HLD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            active_ch <= '0;
`ifdef CMD_SEQNUM_EN
            seq       <= '0;
`endif
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            hold_cnt  <= hold_nx;
            active_ch <= ch_nx;
`ifdef CMD_SEQNUM_EN
            seq       <= seq_nx;
`endif
        end
    end

    assign tx_data_valid  = (state == SEND);
    assign tx_data        = tx_data_valid ? cur_byte : 8'h00;
    assign busy           = (state != IDLE);
    assign tx_data_length = 16'(FRAME_LEN);

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Scoreboard bench for cmd_frame_tx: stimulus queues expected bytes, a negedge monitor pops and compares.
// Define CMD_SEQNUM_EN to include the sequence-number frame run.
module tb_cmd_frame_tx;

    localparam int NUM_CH      = 2;
    localparam int CMD_LEN     = 3;
    localparam int DEB_CYC     = 4;
    localparam int HOLDOFF_CYC = 16;
`ifdef CMD_SEQNUM_EN
    localparam int LEN = 4;
`else
    localparam int LEN = 3;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] ch;
    } exp_t;

    logic                        tx_clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_CH-1:0]           key_n = '1;
    logic [NUM_CH*CMD_LEN*8-1:0] cmd_table = 48'h66FF00_7E8EFF;
    logic                        tx_ready = 1'b1;
    logic [7:0]                  tx_data;
    logic                        tx_data_valid;
    logic [15:0]                 tx_data_length;
    logic                        busy;
    logic [2:0]                  active_ch;

    logic [7:0] rows [2][3] = '{'{8'hFF, 8'h8E, 8'h7E}, '{8'h00, 8'hFF, 8'h66}};

    exp_t sbq[$];
    exp_t e;
    int   applied = 0;
    int   miscompares = 0;
    int   seq_model = 0;
    int   cyc;
    int   gap;
    bit   saw;

    cmd_frame_tx #(
        .NUM_CH(NUM_CH),
        .CMD_LEN(CMD_LEN),
        .DEB_CYC(DEB_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .tx_clk(tx_clk),
        .reset(reset),
        .key_n(key_n),
        .cmd_table(cmd_table),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_length(tx_data_length),
        .busy(busy),
        .active_ch(active_ch)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic push_frame(input int ch);
        for (int b = 0; b < CMD_LEN; b++) begin
            sbq.push_back('{data: rows[ch][b], ch: 3'(ch)});
        end
`ifdef CMD_SEQNUM_EN
        sbq.push_back('{data: 8'(seq_model), ch: 3'(ch)});
        seq_model = (seq_model + 1) % 256;
`endif
    endtask

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (!tx_data_valid && n < budget) begin
            tick(1);
            n++;
        end
        if (!tx_data_valid) check(name, 32'(tx_data_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_q(input string name, input int level, input int budget);
        int n = 0;
        while (sbq.size() > level && n < budget) begin
            tick(1);
            n++;
        end
        if (sbq.size() > level) check(name, 32'(sbq.size()), 32'(level));
    endtask

    always @(negedge tx_clk) begin
        if (!reset) begin
            if (tx_data_valid && tx_ready) begin
                if (sbq.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL sb_extra: got byte %0h ch %0d, required no byte", tx_data, active_ch);
                end else begin
                    e = sbq.pop_front();
                    check("sb_data", 32'(tx_data), 32'(e.data));
                    check("sb_ch", 32'(active_ch), 32'(e.ch));
                    check("sb_len", 32'(tx_data_length), 32'(LEN));
                end
            end else if (!tx_data_valid) begin
                check("idle_data", 32'(tx_data), 32'd0);
            end
        end
    end

    initial begin
        tick(3);
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ch", 32'(active_ch), 32'd0);
        check("rst_len", 32'(tx_data_length), 32'(LEN));
        reset = 1'b0;
        tick(2);

        // single frame on ch0
        push_frame(0);
        key_n = 2'b10;
        tick(10);
        key_n = 2'b11;
        wait_idle("single_idle", 100);
        check("single_drain", 32'(sbq.size()), 32'd0);
        check("single_ch", 32'(active_ch), 32'd0);

        // backpressure on byte 1
        push_frame(0);
        key_n = 2'b10;
        wait_valid("bp_start", 50, cyc);
        tick(1);
        tx_ready = 1'b0;
        key_n = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'(tx_data), 32'h8E);
            check("bp_hold_valid", 32'(tx_data_valid), 32'd1);
            tick(1);
        end
        tx_ready = 1'b1;
        wait_idle("bp_idle", 100);
        check("bp_drain", 32'(sbq.size()), 32'd0);

        // priority, auto-repeat spacing, release hand-over to ch1
        push_frame(0);
        push_frame(0);
        push_frame(1);
        key_n = 2'b00;
        wait_valid("prio_start", 50, cyc);
        check("prio_ch", 32'(active_ch), 32'd0);
        cyc = 0;
        while (tx_data_valid && cyc < 10) begin
            tick(1);
            cyc++;
        end
        gap = 0;
        while (!tx_data_valid && gap < 100) begin
            tick(1);
            gap++;
        end
        check("repeat_gap", 32'(gap), 32'(HOLDOFF_CYC));
        check("repeat_ch", 32'(active_ch), 32'd0);
        tick(1);
        key_n = 2'b01;
        wait_q("prio_rep_done", 3, 200);
        wait_valid("ch1_start", 100, cyc);
        check("ch1_ch", 32'(active_ch), 32'd1);
        key_n = 2'b11;
        wait_idle("prio_idle", 100);
        check("prio_drain", 32'(sbq.size()), 32'd0);

        // 3-cycle glitch must not start a frame
        key_n = 2'b01;
        tick(3);
        key_n = 2'b11;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy) saw = 1'b1;
        end
        check("glitch_nofr", 32'(saw), 32'd0);

        // reset during byte 1 aborts the frame
        sbq.push_back('{data: 8'hFF, ch: 3'd0});
        key_n = 2'b10;
        wait_valid("abort_start", 50, cyc);
        tick(1);
        tx_ready = 1'b0;
        check("abort_byte1", 32'(tx_data), 32'h8E);
        reset = 1'b1;
        #1;
        check("abort_valid_now", 32'(tx_data_valid), 32'd0);
        tick(1);
        check("abort_valid", 32'(tx_data_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        check("abort_ch", 32'(active_ch), 32'd0);
        check("abort_drain", 32'(sbq.size()), 32'd0);
        seq_model = 0;
        push_frame(0);
        tx_ready = 1'b1;
        reset = 1'b0;
        wait_valid("rst_hold_start", 50, cyc);
        check("rst_hold_latency", 32'(cyc), 32'(DEB_CYC + 3));
        key_n = 2'b11;
        wait_idle("rst_hold_idle", 100);
        check("rst_hold_drain", 32'(sbq.size()), 32'd0);

`ifdef CMD_SEQNUM_EN
        // 257 auto-repeated frames: sequence byte wraps FF -> 00
        reset = 1'b1;
        tick(2);
        seq_model = 0;
        reset = 1'b0;
        tick(2);
        check("seq_len", 32'(tx_data_length), 32'd4);
        for (int f = 0; f < 257; f++) begin
            push_frame(0);
        end
        key_n = 2'b10;
        wait_q("seq_last_frame", 3, 6000);
        key_n = 2'b11;
        wait_idle("seq_idle", 100);
        check("seq_drain", 32'(sbq.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
